// File: rtl/instr_cache_if.sv
// ---------------------------------------------------------------------------
// instr_cache_if
// Bundles the two sides of the instruction cache into one interface.
//   CPU fetch side : read, address        -> cache
//                    instruction, busywait <- cache
//   Memory side    : mem_read, mem_address -> instruction memory
//                    mem_readdata, mem_busywait <- instruction memory
//
// Handshake: the CPU holds read/address stable while busywait=1 and takes
// instruction in a cycle where read=1 and busywait=0. The cache holds
// mem_read/mem_address stable while mem_busywait=1; the block on
// mem_readdata is taken in the first mem_read cycle with mem_busywait=0.
//
// Modports: master = CPU plus memory (drives the cache inputs),
//           slave  = the cache itself.
// ---------------------------------------------------------------------------
interface instr_cache_if #(
    parameter int ADDR_W = 10
);
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [31:0]       instruction;
    logic              busywait;
    logic              mem_read;
    logic [ADDR_W-5:0] mem_address;
    logic [127:0]      mem_readdata;
    logic              mem_busywait;

    modport master (
        output read, address, mem_readdata, mem_busywait,
        input  instruction, busywait, mem_read, mem_address
    );

    modport slave (
        input  read, address, mem_readdata, mem_busywait,
        output instruction, busywait, mem_read, mem_address
    );
endinterface

// File: rtl/instr_cache.sv
// ---------------------------------------------------------------------------
// instr_cache
// Direct-mapped, read-only instruction cache with 16-byte lines. A hit
// returns the 32-bit instruction combinationally in the same cycle; a miss
// stalls the CPU (busywait), reads the whole block from instruction memory,
// installs it and then serves the re-presented address as a hit.
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-low reset
//   bus       : instr_cache_if.slave (CPU fetch side and memory side)
//   fsm_state : current controller state (0 IDLE, 1 MEM_READ, 2 UPDATE)
// ---------------------------------------------------------------------------
module instr_cache #(
    parameter int ADDR_W     = 10,
    parameter int NUM_BLOCKS = 8
) (
    input  logic          clk,
    input  logic          reset,
    instr_cache_if.slave  bus,
    output logic [1:0]    fsm_state
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = ADDR_W - 4 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Address split: [1:0] byte (ignored), [3:2] word, then index, then tag.
    logic [1:0]       offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             unused_byte_bits;

    assign offset           = bus.address[3:2];
    assign index            = bus.address[4+IDX_W-1:4];
    assign tag              = bus.address[ADDR_W-1:4+IDX_W];
    assign unused_byte_bits = ^bus.address[1:0];

    logic [NUM_BLOCKS-1:0] valid;
    logic [TAG_W-1:0]      tag_store  [NUM_BLOCKS];
    logic [127:0]          data_store [NUM_BLOCKS];
    logic [127:0]          fill_q;
    logic [127:0]          line;

    logic hit;
    logic fill_en;
    logic line_we;
    logic busy_c;
    logic mem_read_c;
    logic [ADDR_W-5:0] mem_address_c;

    assign line = data_store[index];
    assign hit  = bus.read & valid[index] & (tag_store[index] == tag);

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        busy_c        = 1'b0;
        mem_read_c    = 1'b0;
        mem_address_c = '0;
        fill_en       = 1'b0;
        line_we       = 1'b0;
        case (state)
            S_IDLE: begin
                busy_c = bus.read & ~hit;
                if (bus.read & ~hit) begin
                    state_next = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                busy_c        = 1'b1;
                mem_read_c    = 1'b1;
                // The CPU is stalled, so the current address still names the
                // missing block.
                mem_address_c = bus.address[ADDR_W-1:4];
                if (!bus.mem_busywait) begin
                    fill_en    = 1'b1;
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busy_c     = 1'b1;
                line_we    = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // busywait is forced low while reset is held, even with read=1 and all
    // lines invalid.
    assign bus.busywait    = busy_c & reset;
    assign bus.mem_read    = mem_read_c;
    assign bus.mem_address = mem_address_c;
    assign bus.instruction = hit ? line[{offset, 5'b0} +: 32] : 32'h0;
    assign fsm_state       = state;

    // ------------------------------------------------------------------
    // Controller state, valid bits and fill register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            valid  <= '0;
            fill_q <= '0;
        end else begin
            state <= state_next;
            if (fill_en) begin
                fill_q <= bus.mem_readdata;
            end
            if (line_we) begin
                valid[index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset: they are qualified by valid.
    // A reset mid-fill forces state to IDLE, so no UPDATE write can follow.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_store[index] <= fill_q;
            tag_store[index]  <= tag;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// ---------------------------------------------------------------------------
// tb_instr_cache
// Directed bench for instr_cache with a small instruction-memory model whose
// busy latency (mem_k) is set per test.
// ---------------------------------------------------------------------------
module tb_instr_cache;

    logic       clk;
    logic       reset;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_k    = 3;
    int mem_cnt  = 0;

    instr_cache_if #(.ADDR_W(10)) bus ();

    instr_cache #(.ADDR_W(10), .NUM_BLOCKS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    // Block 0 holds the test program; other blocks hold 0xC0DE0000 | {block, word}.
    function automatic logic [127:0] mem_block(input logic [5:0] b);
        logic [127:0] r;
        if (b == 6'd0) begin
            r = {32'h14FE0000, 32'h00000000, 32'h08050012, 32'h08060012};
        end else begin
            for (int w = 0; w < 4; w++) begin
                r[32*w +: 32] = 32'hC0DE0000 | (32'(b) << 4) | 32'(w);
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        mem_cnt <= bus.mem_read ? mem_cnt + 1 : 0;
    end

    // Busy for the first mem_k cycles of a request, then one ready cycle.
    assign bus.mem_busywait = bus.mem_read && (mem_cnt < mem_k);
    assign bus.mem_readdata = mem_block(bus.mem_address);

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present a fetch and follow it until busywait drops, counting stall and
    // memory-request cycles.
    task automatic fetch(input string tag, input logic [9:0] addr, input logic [31:0] exp_instr,
                         input int exp_busy, input int exp_mem, input logic [5:0] exp_maddr);
        int  busy = 0;
        int  memc = 0;
        bit  done = 0;
        @(posedge clk);
        #1;
        bus.read    = 1'b1;
        bus.address = addr;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.busywait) begin
                busy++;
                if (bus.mem_read) begin
                    memc++;
                    check_eq({tag, " mem_address"}, 32'(bus.mem_address), 32'(exp_maddr));
                end
                @(posedge clk);
                #1;
            end else begin
                done = 1;
                check_eq({tag, " instruction"}, bus.instruction, exp_instr);
                check_eq({tag, " mem_read idle"}, 32'(bus.mem_read), 32'd0);
            end
        end
        if (!done) begin
            check_eq({tag, " timeout busywait"}, 32'(bus.busywait), 32'd0);
        end
        check_eq({tag, " busy cycles"}, 32'(busy), 32'(exp_busy));
        check_eq({tag, " mem_read cycles"}, 32'(memc), 32'(exp_mem));
    endtask

    task automatic idle_read0(input logic [9:0] addr);
        @(posedge clk);
        #1;
        bus.read    = 1'b0;
        bus.address = addr;
        @(negedge clk);
        check_eq("read0 busywait", 32'(bus.busywait), 32'd0);
        check_eq("read0 instruction", bus.instruction, 32'd0);
        check_eq("read0 mem_read", 32'(bus.mem_read), 32'd0);
        check_eq("read0 state", 32'(fsm_state), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b0;
        bus.read    = 1'b1;
        bus.address = 10'h000;

        // Reset held with read=1: all outputs quiet.
        repeat (2) @(negedge clk);
        check_eq("reset busywait", 32'(bus.busywait), 32'd0);
        check_eq("reset instruction", bus.instruction, 32'd0);
        check_eq("reset mem_read", 32'(bus.mem_read), 32'd0);
        check_eq("reset mem_address", 32'(bus.mem_address), 32'd0);
        check_eq("reset state", 32'(fsm_state), 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        bus.read = 1'b0;

        // Cold miss, k=3: 6 stall cycles, 4 memory-request cycles.
        mem_k = 3;
        fetch("cold 000", 10'h000, 32'h08060012, 6, 4, 6'h00);

        // Same-block hits on consecutive cycles.
        fetch("hit 004", 10'h004, 32'h08050012, 0, 0, 6'h00);
        fetch("hit 008", 10'h008, 32'h00000000, 0, 0, 6'h00);
        fetch("hit 00C", 10'h00C, 32'h14FE0000, 0, 0, 6'h00);

        // Conflict on index 0: tag 1 evicts tag 0 and back.
        fetch("conflict 080", 10'h080, 32'hC0DE0080, 6, 4, 6'h08);
        fetch("conflict 000", 10'h000, 32'h08060012, 6, 4, 6'h00);

        // Zero-latency memory: 3 stall cycles, then line 1 hits.
        mem_k = 0;
        fetch("k0 010", 10'h010, 32'hC0DE0010, 3, 1, 6'h01);
        fetch("k0 hit 014", 10'h014, 32'hC0DE0011, 0, 0, 6'h01);
        fetch("line0 kept", 10'h000, 32'h08060012, 0, 0, 6'h00);

        // Reset during the 2nd MEM_READ cycle of a miss on 0x020.
        mem_k = 3;
        @(posedge clk);
        #1;
        bus.read    = 1'b1;
        bus.address = 10'h020;
        @(posedge clk);
        #1;
        check_eq("midfill mem_read 1st", 32'(bus.mem_read), 32'd1);
        @(posedge clk);
        #1;
        check_eq("midfill mem_read 2nd", 32'(bus.mem_read), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("midfill rst mem_read", 32'(bus.mem_read), 32'd0);
        check_eq("midfill rst busywait", 32'(bus.busywait), 32'd0);
        check_eq("midfill rst state", 32'(fsm_state), 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        bus.read = 1'b0;
        fetch("after rst 000", 10'h000, 32'h08060012, 6, 4, 6'h00);

        // read=0 with cached and uncached addresses: nothing happens.
        idle_read0(10'h000);
        idle_read0(10'h080);
        idle_read0(10'h3FC);
        idle_read0(10'h024);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
